// File: rtl/irq_timer_ctrl.sv
// Machine interrupt source: memory-mapped 64-bit mtime/mtimecmp timer plus a synchronized
// external interrupt, arbitrated into a single held trap request toward the CSR unit.
module irq_timer_ctrl #(
    parameter logic [31:0] TIMER_BASE = 32'h0000_0400,
    parameter int unsigned PRESCALE   = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        wr_en,
    input  logic        rd_en,
    output logic [31:0] rdata,
    input  logic        ext_irq,
    input  logic        trap_ack,
    input  logic        mret,
    output logic        trap_handle,
    output logic [31:0] irq_cause
);

    localparam int unsigned     PS_W      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PS_W-1:0] PS_LAST   = PS_W'(PRESCALE - 1);
    localparam logic [31:0]     CAUSE_EXT = 32'h8000_000B;
    localparam logic [31:0]     CAUSE_TIM = 32'h8000_0007;

    typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

    state_t          state;
    logic [63:0]     mtime;
    logic [63:0]     mtimecmp;
    logic [1:0]      ctrl;
    logic [PS_W-1:0] ps_cnt;
    logic            ext_s1, ext_s2, ext_s3;
    logic            ext_pend;

    logic tim_en, ext_en, tick, tim_pend, ext_rise, ext_clr;
    logic sel_mtime_lo, sel_mtime_hi, sel_cmp_lo, sel_cmp_hi, sel_ctrl;

    assign sel_mtime_lo = (addr == TIMER_BASE);
    assign sel_mtime_hi = (addr == TIMER_BASE + 32'h04);
    assign sel_cmp_lo   = (addr == TIMER_BASE + 32'h08);
    assign sel_cmp_hi   = (addr == TIMER_BASE + 32'h0C);
    assign sel_ctrl     = (addr == TIMER_BASE + 32'h10);

    assign tim_en   = ctrl[0];
    assign ext_en   = ctrl[1];
    assign tick     = tim_en && (ps_cnt == PS_LAST);
    assign tim_pend = tim_en && (mtime >= mtimecmp);
    assign ext_rise = ext_s2 && !ext_s3;
    assign ext_clr  = (state == REQ) && trap_ack && (irq_cause == CAUSE_EXT);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ps_cnt <= '0;
        end else if (tim_en) begin
            ps_cnt <= (ps_cnt == PS_LAST) ? '0 : ps_cnt + PS_W'(1);
        end
    end

    // A software write to either half takes priority and swallows that cycle's increment.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mtime <= '0;
        end else if (wr_en && sel_mtime_lo) begin
            mtime[31:0] <= wdata;
        end else if (wr_en && sel_mtime_hi) begin
            mtime[63:32] <= wdata;
        end else if (tick) begin
            mtime <= mtime + 64'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mtimecmp <= '1;
            ctrl     <= '0;
        end else if (wr_en) begin
            if (sel_cmp_lo) mtimecmp[31:0]  <= wdata;
            if (sel_cmp_hi) mtimecmp[63:32] <= wdata;
            if (sel_ctrl)   ctrl            <= wdata[1:0];
        end
    end

    // Two synchronizer flops, then a third to detect the rising edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ext_s1 <= 1'b0;
            ext_s2 <= 1'b0;
            ext_s3 <= 1'b0;
        end else begin
            ext_s1 <= ext_irq;
            ext_s2 <= ext_s1;
            ext_s3 <= ext_s2;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ext_pend <= 1'b0;
        end else if (ext_en && ext_rise) begin
            ext_pend <= 1'b1;
        end else if (ext_clr) begin
            ext_pend <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            trap_handle <= 1'b0;
            irq_cause   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (ext_pend) begin
                        state       <= REQ;
                        trap_handle <= 1'b1;
                        irq_cause   <= CAUSE_EXT;
                    end else if (tim_pend) begin
                        state       <= REQ;
                        trap_handle <= 1'b1;
                        irq_cause   <= CAUSE_TIM;
                    end
                end
                REQ: begin
                    if (trap_ack) begin
                        state       <= SERVICE;
                        trap_handle <= 1'b0;
                    end
                end
                SERVICE: begin
                    if (mret) state <= IDLE;
                end
                default: begin
                    state       <= IDLE;
                    trap_handle <= 1'b0;
                end
            endcase
        end
    end

    // NOTE: rdata gets a default before any branch so no latch is inferred.
    always_comb begin
        rdata = '0;
        if (rd_en) begin
            if (sel_mtime_lo)      rdata = mtime[31:0];
            else if (sel_mtime_hi) rdata = mtime[63:32];
            else if (sel_cmp_lo)   rdata = mtimecmp[31:0];
            else if (sel_cmp_hi)   rdata = mtimecmp[63:32];
            else if (sel_ctrl)     rdata = {30'd0, ctrl};
        end
    end

endmodule

// File: tb/tb_irq_timer_ctrl.sv
// Directed bench for irq_timer_ctrl: reset, timer fire, carry/wrap, external priority,
// ack/edge collision and asynchronous reset mid-request.
module tb_irq_timer_ctrl;

    localparam logic [31:0] BASE      = 32'h0000_0400;
    localparam logic [31:0] CAUSE_EXT = 32'h8000_000B;
    localparam logic [31:0] CAUSE_TIM = 32'h8000_0007;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        wr_en;
    logic        rd_en;
    logic [31:0] rdata;
    logic        ext_irq;
    logic        trap_ack;
    logic        mret;
    logic        trap_handle;
    logic [31:0] irq_cause;

    int vectors    = 0;
    int miscompares = 0;

    irq_timer_ctrl #(.TIMER_BASE(BASE), .PRESCALE(1)) dut (
        .clk         (clk),
        .rst         (rst),
        .addr        (addr),
        .wdata       (wdata),
        .wr_en       (wr_en),
        .rd_en       (rd_en),
        .rdata       (rdata),
        .ext_irq     (ext_irq),
        .trap_ack    (trap_ack),
        .mret        (mret),
        .trap_handle (trap_handle),
        .irq_cause   (irq_cause)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [7:0] off, input logic [31:0] data);
        addr  = BASE + {24'd0, off};
        wdata = data;
        wr_en = 1'b1;
        step();
        wr_en = 1'b0;
        addr  = '0;
        wdata = '0;
    endtask

    task automatic rd_check(input string tag, input logic [7:0] off, input logic [31:0] exp);
        addr  = BASE + {24'd0, off};
        rd_en = 1'b1;
        #1;
        check(tag, {32'd0, rdata}, {32'd0, exp});
        rd_en = 1'b0;
        addr  = '0;
    endtask

    task automatic do_reset();
        ext_irq  = 1'b0;
        trap_ack = 1'b0;
        mret     = 1'b0;
        rst      = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int waited;
        addr = '0; wdata = '0; wr_en = 1'b0; rd_en = 1'b0;
        ext_irq = 1'b0; trap_ack = 1'b0; mret = 1'b0; rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        step();

        // Reset state and register map
        check("rst_handle", {63'd0, trap_handle}, 64'd0);
        check("rst_cause", {32'd0, irq_cause}, 64'd0);
        rd_check("rst_cmp_lo", 8'h08, 32'hFFFF_FFFF);
        rd_check("rst_cmp_hi", 8'h0C, 32'hFFFF_FFFF);
        rd_check("rst_ctrl", 8'h10, 32'h0);
        rd_check("rst_mtime_lo", 8'h00, 32'h0);
        addr = BASE + 32'h08;
        #1;
        check("rd_en_low", {32'd0, rdata}, 64'd0);
        addr = '0;
        wr(8'h10, 32'hFFFF_FFFC);
        rd_check("ctrl_mask", 8'h10, 32'h0);
        wr(8'h14, 32'h0000_0003);
        rd_check("unmapped_ctrl", 8'h10, 32'h0);
        rd_check("unmapped_rd", 8'h14, 32'h0);

        // Timer fire at mtime == 10
        wr(8'h08, 32'd10);
        wr(8'h0C, 32'd0);
        wr(8'h10, 32'd1);
        repeat (10) step();
        rd_check("tim_mtime10", 8'h00, 32'd10);
        check("tim_not_yet", {63'd0, trap_handle}, 64'd0);
        step();
        check("tim_fire", {63'd0, trap_handle}, 64'd1);
        check("tim_cause", {32'd0, irq_cause}, {32'd0, CAUSE_TIM});
        mret = 1'b1; step(); mret = 1'b0;
        check("mret_in_req", {63'd0, trap_handle}, 64'd1);
        trap_ack = 1'b1; step(); trap_ack = 1'b0;
        check("ack_drop", {63'd0, trap_handle}, 64'd0);
        trap_ack = 1'b1; step(); trap_ack = 1'b0;
        check("ack_in_service", {63'd0, trap_handle}, 64'd0);
        step();
        check("service_hold", {63'd0, trap_handle}, 64'd0);
        mret = 1'b1; step(); mret = 1'b0;
        check("mret_gap", {63'd0, trap_handle}, 64'd0);
        step();
        check("tim_reassert", {63'd0, trap_handle}, 64'd1);
        check("tim_reassert_cause", {32'd0, irq_cause}, {32'd0, CAUSE_TIM});

        // Carry and wrap
        do_reset();
        wr(8'h10, 32'd1);
        wr(8'h04, 32'd0);
        wr(8'h00, 32'hFFFF_FFFF);
        rd_check("wr_wins_lo", 8'h00, 32'hFFFF_FFFF);
        step();
        rd_check("carry_hi", 8'h04, 32'd1);
        rd_check("carry_lo", 8'h00, 32'd0);
        wr(8'h04, 32'hFFFF_FFFF);
        wr(8'h00, 32'hFFFF_FFFF);
        rd_check("ones_hi", 8'h04, 32'hFFFF_FFFF);
        step();
        rd_check("wrap_lo", 8'h00, 32'd0);
        rd_check("wrap_hi", 8'h04, 32'd0);
        check("wrap_req", {63'd0, trap_handle}, 64'd1);
        check("wrap_cause", {32'd0, irq_cause}, {32'd0, CAUSE_TIM});
        step();
        check("req_held", {63'd0, trap_handle}, 64'd1);

        // External over timer, both pending on the same edge
        do_reset();
        wr(8'h10, 32'd3);
        wr(8'h0C, 32'd0);
        ext_irq = 1'b1;
        step();
        step();
        check("pri_quiet1", {63'd0, trap_handle}, 64'd0);
        wr(8'h08, 32'd0);
        check("pri_quiet2", {63'd0, trap_handle}, 64'd0);
        step();
        check("pri_req", {63'd0, trap_handle}, 64'd1);
        check("pri_cause_ext", {32'd0, irq_cause}, {32'd0, CAUSE_EXT});
        ext_irq = 1'b0;
        trap_ack = 1'b1; step(); trap_ack = 1'b0;
        mret = 1'b1; step(); mret = 1'b0;
        step();
        check("pri_second_req", {63'd0, trap_handle}, 64'd1);
        check("pri_cause_tim", {32'd0, irq_cause}, {32'd0, CAUSE_TIM});

        // New external edge on the same cycle as trap_ack
        do_reset();
        wr(8'h10, 32'd2);
        ext_irq = 1'b1;
        repeat (3) step();
        check("ext_quiet", {63'd0, trap_handle}, 64'd0);
        step();
        check("ext_req", {63'd0, trap_handle}, 64'd1);
        check("ext_cause", {32'd0, irq_cause}, {32'd0, CAUSE_EXT});
        ext_irq = 1'b0;
        step();
        ext_irq = 1'b1;
        step();
        step();
        trap_ack = 1'b1; step(); trap_ack = 1'b0;
        check("coll_ack_drop", {63'd0, trap_handle}, 64'd0);
        step();
        check("coll_service", {63'd0, trap_handle}, 64'd0);
        mret = 1'b1; step(); mret = 1'b0;
        check("coll_gap", {63'd0, trap_handle}, 64'd0);
        step();
        check("coll_reissue", {63'd0, trap_handle}, 64'd1);
        check("coll_cause", {32'd0, irq_cause}, {32'd0, CAUSE_EXT});

        // Asynchronous reset while the request is held
        #2;
        rst = 1'b0;
        #1;
        check("async_rst_handle", {63'd0, trap_handle}, 64'd0);
        check("async_rst_cause", {32'd0, irq_cause}, 64'd0);
        ext_irq = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (5) step();
        check("post_rst_quiet", {63'd0, trap_handle}, 64'd0);
        rd_check("post_rst_ctrl", 8'h10, 32'd0);
        wr(8'h10, 32'd2);
        ext_irq = 1'b1;
        waited = 0;
        for (int i = 0; i < 8; i++) begin
            if (!trap_handle) begin
                step();
                waited++;
            end
        end
        check("new_event_req", {63'd0, trap_handle}, 64'd1);
        check("new_event_latency", 64'(waited), 64'd4);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
